// File: rtl/router_sw_alloc_pkg.sv
// Shared route codes, output-port indices and allocator state type for the
// router switch allocator and the crossbar.
package router_sw_alloc_pkg;

  localparam int CODE_W    = 3;
  localparam int NUM_PORTS = 4;

  localparam logic [CODE_W-1:0] EMPTY          = 3'd0;
  localparam logic [CODE_W-1:0] OUT_LOCAL_PORT = 3'd1;
  localparam logic [CODE_W-1:0] OUT_X1_PORT    = 3'd2;
  localparam logic [CODE_W-1:0] OUT_X2_PORT    = 3'd3;
  localparam logic [CODE_W-1:0] OUT_Y1_PORT    = 3'd4;

  localparam int OUT_IDX_LOCAL = 0;
  localparam int OUT_IDX_X1    = 1;
  localparam int OUT_IDX_X2    = 2;
  localparam int OUT_IDX_Y1    = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // EMPTY and any unassigned code decode to no request at all.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [CODE_W-1:0] code);
    port_onehot = '0;
    case (code)
      OUT_LOCAL_PORT: port_onehot[OUT_IDX_LOCAL] = 1'b1;
      OUT_X1_PORT:    port_onehot[OUT_IDX_X1]    = 1'b1;
      OUT_X2_PORT:    port_onehot[OUT_IDX_X2]    = 1'b1;
      OUT_Y1_PORT:    port_onehot[OUT_IDX_Y1]    = 1'b1;
      default:        port_onehot = '0;
    endcase
  endfunction

endpackage

// File: rtl/router_sw_alloc_if.sv
// Request/grant bundle between the input route-compute stages, the switch
// allocator and the crossbar.
interface router_sw_alloc_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int SELW  = 2
);
  logic [N_IN-1:0]                               req_valid;
  logic [router_sw_alloc_pkg::CODE_W*N_IN-1:0]   req_port;
  logic [N_IN-1:0]                               req_tail;
  logic [N_OUT-1:0]                              out_ready;
  logic [N_IN-1:0]                               gnt;
  logic [SELW*N_OUT-1:0]                         xbar_sel;
  logic [N_OUT-1:0]                              xbar_vld;
  logic [N_OUT-1:0]                              busy;

  modport master (
    output req_valid, req_port, req_tail, out_ready,
    input  gnt, xbar_sel, xbar_vld, busy
  );

  modport slave (
    input  req_valid, req_port, req_tail, out_ready,
    output gnt, xbar_sel, xbar_vld, busy
  );
endinterface

// File: rtl/router_sw_alloc_rr_arb.sv
// Combinational N_IN-way round-robin picker: first requester at or after ptr,
// wrapping explicitly so N_IN need not be a power of two.
module router_rr_arb #(
  parameter int N_IN = 4,
  parameter int SELW = 2
) (
  input  logic [N_IN-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [N_IN-1:0] gnt_oh,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);
  logic [SELW-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = ptr;
    for (int k = 0; k < N_IN; k++) begin
      if (!any && req[cand]) begin
        any          = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
      cand = (cand == SELW'(N_IN - 1)) ? '0 : cand + SELW'(1);
    end
  end
endmodule

// File: rtl/router_sw_alloc.sv
// Switch allocator: per-output round-robin arbitration with a wormhole lock
// held from head flit to tail flit; drives crossbar selects and input pops.
module router_sw_alloc
  import router_sw_alloc_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  router_sw_alloc_if.slave bus
);
  logic [N_OUT-1:0]      dec [N_IN];
  logic [N_IN-1:0]       gnt_src [N_OUT];
  logic [N_OUT-1:0]      gnt_by_in [N_IN];
  logic [N_IN-1:0]       gnt_w;
  logic [N_OUT-1:0]      busy_w;
  logic [N_OUT-1:0]      vld_w;
  logic [SELW*N_OUT-1:0] sel_w;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      dec[i] = N_OUT'(port_onehot(bus.req_port[CODE_W*i +: CODE_W]));
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    logic [N_IN-1:0] req_vec;
    logic [N_IN-1:0] arb_oh;
    logic [SELW-1:0] arb_idx;
    logic            arb_any;
    alloc_state_e    state_q, state_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            fire;

    always_comb begin
      for (int i = 0; i < N_IN; i++) begin
        req_vec[i] = bus.req_valid[i] & dec[i][o];
      end
    end

    router_rr_arb #(.N_IN(N_IN), .SELW(SELW)) u_arb (
      .req     (req_vec),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .any     (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    // Allocation never grants in the same cycle; the lock only releases on a tail transfer.
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      fire    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en && arb_any) begin
            owner_d = arb_idx;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          fire = en & bus.req_valid[owner_q] & bus.out_ready[o];
          if (fire && bus.req_tail[owner_q]) begin
            state_d = ST_IDLE;
            ptr_d   = (owner_q == SELW'(N_IN - 1)) ? '0 : owner_q + SELW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign gnt_src[o]              = fire ? (N_IN'(1) << owner_q) : '0;
    assign busy_w[o]               = (state_q == ST_LOCKED);
    assign vld_w[o]                = fire;
    assign sel_w[SELW*o +: SELW]   = (state_q == ST_LOCKED) ? owner_q : '0;

    always @(posedge clk) begin
      if (rst_n) begin
        assert ($onehot0(arb_oh))
          else $error("arbiter grant not one-hot on output %0d", o);
        if (state_q == ST_LOCKED && bus.req_valid[owner_q])
          assert (dec[owner_q][o])
            else $error("input %0d changed route mid-packet while owning output %0d", owner_q, o);
      end
    end
  end

  always_comb begin
    gnt_w = '0;
    for (int o = 0; o < N_OUT; o++) begin
      gnt_w = gnt_w | gnt_src[o];
    end
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      for (int o = 0; o < N_OUT; o++) begin
        gnt_by_in[i][o] = gnt_src[o][i];
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        assert ($onehot0(gnt_by_in[i]))
          else $error("input %0d granted by more than one output", i);
      end
    end
  end

  assign bus.gnt      = gnt_w;
  assign bus.busy     = busy_w;
  assign bus.xbar_vld = vld_w;
  assign bus.xbar_sel = sel_w;

endmodule
